// File: rtl/mem_pkg.sv
// Shared definitions for the memory pipeline stage.
//   - Load opcode ranges (word, half-word, byte loads)
//   - width_e : access width of a load
//   - state_e : split-load sequencer states
//   - width_of / is_misaligned : load decode helpers
package mem_pkg;

    localparam logic [4:0] OP_LW_FIRST = 5'd3;
    localparam logic [4:0] OP_LW_LAST  = 5'd5;
    localparam logic [4:0] OP_LH_FIRST = 5'd6;
    localparam logic [4:0] OP_LH_LAST  = 5'd8;
    localparam logic [4:0] OP_LB_FIRST = 5'd9;
    localparam logic [4:0] OP_LB_LAST  = 5'd11;

    typedef enum logic [1:0] {
        W_WORD = 2'd0,
        W_HALF = 2'd1,
        W_BYTE = 2'd2
    } width_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Access width of a load opcode; anything outside the half/byte ranges is treated as a word.
    function automatic width_e width_of(input logic [4:0] op);
        width_e w;
        if (op >= OP_LB_FIRST && op <= OP_LB_LAST) begin
            w = W_BYTE;
        end else if (op >= OP_LH_FIRST && op <= OP_LH_LAST) begin
            w = W_HALF;
        end else begin
            w = W_WORD;
        end
        return w;
    endfunction

    // A load crosses a word boundary when its bytes do not all fit in one aligned word.
    function automatic logic is_misaligned(input width_e w, input logic [1:0] off);
        logic m;
        case (w)
            W_WORD:  m = (off != 2'd0);
            W_HALF:  m = (off == 2'd3);
            W_BYTE:  m = 1'b0;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data extraction.
//   rd_data : word returned by data memory this cycle (upper word of a split load)
//   lo_buf  : first (lower) word of a split load
//   split   : load was split across two aligned words
//   offset  : byte offset of the load address within its word
//   width   : access width
//   value   : little-endian, zero-extended load result
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] lo_buf,
    input  logic              split,
    input  logic [1:0]        offset,
    input  width_e            width,
    output logic [DATA_W-1:0] value
);

    logic [2*DATA_W-1:0] cat_s;
    logic [DATA_W-1:0]   shifted_s;

    // Shift the (possibly two-word) window down to the addressed byte, then mask to width.
    always_comb begin
        cat_s     = {2*DATA_W{1'b0}};
        shifted_s = {DATA_W{1'b0}};
        value     = {DATA_W{1'b0}};
        if (split) begin
            cat_s = {rd_data, lo_buf};
        end else begin
            cat_s = {{DATA_W{1'b0}}, rd_data};
        end
        shifted_s = DATA_W'(cat_s >> {offset, 3'b000});
        case (width)
            W_WORD:  value = shifted_s;
            W_HALF:  value = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
            W_BYTE:  value = {{(DATA_W-8){1'b0}}, shifted_s[7:0]};
            default: value = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds the instruction leaving execute, issues its data
// load (splitting word-crossing loads into two aligned reads) and presents the
// mem-stage and wb-stage forwarding state back to execute.
//   clk, rst            : clock, synchronous active-high reset
//   halt                : global freeze
//   ex_*                : instruction leaving execute
//   rd_en/rd_addr       : aligned data-memory read request
//   rd_data             : read data, one cycle after rd_en
//   stall_mem           : holds execute and upstream
//   mem_*/is_load_mem   : instruction currently in mem
//   wb_*/halt_in_wb     : instruction currently in wb
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              ex_bubble,
    input  logic [4:0]        ex_opcode,
    input  logic [4:0]        ex_tgt_1,
    input  logic [4:0]        ex_tgt_2,
    input  logic [DATA_W-1:0] ex_result_1,
    input  logic [DATA_W-1:0] ex_result_2,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic              ex_halt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              stall_mem,
    output logic [4:0]        mem_tgt_1,
    output logic [4:0]        mem_tgt_2,
    output logic [DATA_W-1:0] mem_result_out_1,
    output logic [DATA_W-1:0] mem_result_out_2,
    output logic              mem_bubble,
    output logic              is_load_mem,
    output logic [4:0]        mem_opcode_out,
    output logic [4:0]        wb_tgt_1,
    output logic [4:0]        wb_tgt_2,
    output logic [DATA_W-1:0] wb_result_out_1,
    output logic [DATA_W-1:0] wb_result_out_2,
    output logic              wb_bubble,
    output logic              halt_in_wb
);

    // mem stage register
    logic              mem_bubble_r;
    logic [4:0]        mem_opcode_r;
    logic [4:0]        mem_tgt1_r;
    logic [4:0]        mem_tgt2_r;
    logic [DATA_W-1:0] mem_res1_r;
    logic [DATA_W-1:0] mem_res2_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_is_load_r;
    logic              mem_is_store_r;
    logic              mem_halt_r;

    // wb stage register
    logic              wb_bubble_r;
    logic [4:0]        wb_tgt1_r;
    logic [4:0]        wb_tgt2_r;
    logic [DATA_W-1:0] wb_res1_r;
    logic [DATA_W-1:0] wb_res2_r;
    logic              wb_is_load_r;
    width_e            wb_width_r;
    logic [1:0]        wb_off_r;
    logic              wb_split_r;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [DATA_W-1:0] lo_buf_r;
    logic              halt_in_wb_r;

    logic              mem_valid_s;
    logic              mem_load_s;
    width_e            mem_width_s;
    logic              mem_misal_s;
    logic [ADDR_W-1:0] base_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              stall_s;
    logic              mem_adv_s;
    logic              mem_kill_s;
    logic [DATA_W-1:0] align_s;

    // Once a halt has reached wb nothing behind it is allowed to act.
    assign mem_valid_s = !mem_bubble_r && !halt_in_wb_r;
    assign mem_load_s  = mem_valid_s && mem_is_load_r && !mem_is_store_r;
    assign mem_width_s = width_of(mem_opcode_r);
    assign mem_misal_s = is_misaligned(mem_width_s, mem_addr_r[1:0]);
    assign base_s      = {mem_addr_r[ADDR_W-1:2], 2'b00};

    // Split-load sequencer: read request, read address, stall and next state.
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = 1'b0;
        rd_addr_s   = base_s;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_load_s) begin
                    rd_en_s = 1'b1;
                    if (mem_misal_s) begin
                        stall_s     = 1'b1;
                        state_nxt_s = SPLIT;
                    end else begin
                        stall_s     = 1'b0;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            SPLIT: begin
                // Second aligned word; address arithmetic wraps at the top of memory.
                rd_en_s     = 1'b1;
                rd_addr_s   = base_s + ADDR_W'(3'd4);
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign mem_adv_s  = !halt && !stall_s;
    // Instructions following a halt are turned into bubbles.
    assign mem_kill_s = halt_in_wb_r || (mem_valid_s && mem_halt_r);

    // Sequencer state and first-word buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            lo_buf_r <= {DATA_W{1'b0}};
        end else if (!halt) begin
            state_r <= state_nxt_s;
            if (state_r == SPLIT) begin
                lo_buf_r <= rd_data;
            end
        end
    end

    // mem stage register: captures execute output unless stalled or frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_bubble_r   <= 1'b1;
            mem_opcode_r   <= 5'd0;
            mem_tgt1_r     <= 5'd0;
            mem_tgt2_r     <= 5'd0;
            mem_res1_r     <= {DATA_W{1'b0}};
            mem_res2_r     <= {DATA_W{1'b0}};
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_is_load_r  <= 1'b0;
            mem_is_store_r <= 1'b0;
            mem_halt_r     <= 1'b0;
        end else if (mem_adv_s) begin
            mem_opcode_r   <= ex_opcode;
            mem_res1_r     <= ex_result_1;
            mem_res2_r     <= ex_result_2;
            mem_addr_r     <= ex_addr;
            mem_is_store_r <= ex_is_store;
            if (mem_kill_s) begin
                mem_bubble_r  <= 1'b1;
                mem_tgt1_r    <= 5'd0;
                mem_tgt2_r    <= 5'd0;
                mem_is_load_r <= 1'b0;
                mem_halt_r    <= 1'b0;
            end else begin
                mem_bubble_r  <= ex_bubble;
                mem_tgt1_r    <= ex_tgt_1;
                mem_tgt2_r    <= ex_tgt_2;
                mem_is_load_r <= ex_is_load;
                mem_halt_r    <= ex_halt;
            end
        end
    end

    // wb stage register: takes the mem instruction when it leaves mem, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_bubble_r  <= 1'b1;
            wb_tgt1_r    <= 5'd0;
            wb_tgt2_r    <= 5'd0;
            wb_res1_r    <= {DATA_W{1'b0}};
            wb_res2_r    <= {DATA_W{1'b0}};
            wb_is_load_r <= 1'b0;
            wb_width_r   <= W_WORD;
            wb_off_r     <= 2'd0;
            wb_split_r   <= 1'b0;
        end else if (!halt) begin
            if (!stall_s && mem_valid_s) begin
                wb_bubble_r  <= 1'b0;
                wb_tgt1_r    <= mem_tgt1_r;
                wb_tgt2_r    <= mem_tgt2_r;
                wb_res1_r    <= mem_res1_r;
                wb_res2_r    <= mem_res2_r;
                wb_is_load_r <= mem_load_s;
                wb_width_r   <= mem_width_s;
                wb_off_r     <= mem_addr_r[1:0];
                wb_split_r   <= (state_r == SPLIT);
            end else begin
                wb_bubble_r  <= 1'b1;
                wb_tgt1_r    <= 5'd0;
                wb_tgt2_r    <= 5'd0;
                wb_is_load_r <= 1'b0;
                wb_split_r   <= 1'b0;
            end
        end
    end

    // Sticky halt flag, raised when a valid halt instruction enters wb.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_in_wb_r <= 1'b0;
        end else if (!halt && !stall_s && mem_valid_s && mem_halt_r) begin
            halt_in_wb_r <= 1'b1;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .rd_data (rd_data),
        .lo_buf  (lo_buf_r),
        .split   (wb_split_r),
        .offset  (wb_off_r),
        .width   (wb_width_r),
        .value   (align_s)
    );

    assign rd_en            = rd_en_s;
    assign rd_addr          = rd_addr_s;
    assign stall_mem        = stall_s;
    assign mem_tgt_1        = mem_tgt1_r;
    assign mem_tgt_2        = mem_tgt2_r;
    assign mem_result_out_1 = mem_res1_r;
    assign mem_result_out_2 = mem_res2_r;
    assign mem_bubble       = mem_bubble_r;
    assign is_load_mem      = mem_is_load_r;
    assign mem_opcode_out   = mem_opcode_r;
    assign wb_tgt_1         = wb_tgt1_r;
    assign wb_tgt_2         = wb_tgt2_r;
    // Load data arrives from memory during the wb cycle, so it is extracted combinationally.
    assign wb_result_out_1  = (wb_is_load_r && !wb_bubble_r) ? align_s : wb_res1_r;
    assign wb_result_out_2  = wb_res2_r;
    assign wb_bubble        = wb_bubble_r;
    assign halt_in_wb       = halt_in_wb_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a small registered data memory.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, halt, ex_bubble, ex_is_load, ex_is_store, ex_halt;
    logic [4:0]  ex_opcode, ex_tgt_1, ex_tgt_2;
    logic [31:0] ex_result_1, ex_result_2, ex_addr;
    logic        rd_en, stall_mem, mem_bubble, is_load_mem, wb_bubble, halt_in_wb;
    logic [31:0] rd_addr, rd_data;
    logic [4:0]  mem_tgt_1, mem_tgt_2, mem_opcode_out, wb_tgt_1, wb_tgt_2;
    logic [31:0] mem_result_out_1, mem_result_out_2, wb_result_out_1, wb_result_out_2;

    int n_vec  = 0;
    int n_miss = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .halt(halt),
        .ex_bubble(ex_bubble), .ex_opcode(ex_opcode),
        .ex_tgt_1(ex_tgt_1), .ex_tgt_2(ex_tgt_2),
        .ex_result_1(ex_result_1), .ex_result_2(ex_result_2),
        .ex_addr(ex_addr), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_halt(ex_halt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .stall_mem(stall_mem),
        .mem_tgt_1(mem_tgt_1), .mem_tgt_2(mem_tgt_2),
        .mem_result_out_1(mem_result_out_1), .mem_result_out_2(mem_result_out_2),
        .mem_bubble(mem_bubble), .is_load_mem(is_load_mem),
        .mem_opcode_out(mem_opcode_out),
        .wb_tgt_1(wb_tgt_1), .wb_tgt_2(wb_tgt_2),
        .wb_result_out_1(wb_result_out_1), .wb_result_out_2(wb_result_out_2),
        .wb_bubble(wb_bubble), .halt_in_wb(halt_in_wb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'hDEAD_BEEF;
            32'h0000_0200: mem_word = 32'hAABB_CCDD;
            32'h0000_0300: mem_word = 32'h4433_2211;
            32'h0000_0304: mem_word = 32'h8877_6655;
            32'hFFFF_FFFC: mem_word = 32'h1234_5678;
            32'h0000_0000: mem_word = 32'h9ABC_DEF0;
            default:       mem_word = 32'h0000_0000;
        endcase
    endfunction

    // Data memory: one-cycle read latency, frozen by the global halt.
    always @(posedge clk) begin
        if (rd_en && !halt) rd_data <= mem_word(rd_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] t1, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] a, input logic ld,
                         input logic hl);
        ex_bubble   = 1'b0;
        ex_opcode   = op;
        ex_tgt_1    = t1;
        ex_tgt_2    = 5'd0;
        ex_result_1 = r1;
        ex_result_2 = r2;
        ex_addr     = a;
        ex_is_load  = ld;
        ex_is_store = 1'b0;
        ex_halt     = hl;
    endtask

    task automatic idle_ex();
        ex_bubble  = 1'b1;
        ex_is_load = 1'b0;
        ex_halt    = 1'b0;
        ex_tgt_1   = 5'd0;
    endtask

    // Single-cycle aligned load: request in mem cycle, data extracted in wb cycle.
    task automatic aligned_load(input string tag, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] exp_addr, input logic [31:0] exp_val);
        drive(op, 5'd1, 32'h0, a + 32'd4, a, 1'b1, 1'b0);
        tick();
        idle_ex();
        chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
        chk({tag, "_rd_addr"}, rd_addr, exp_addr);
        chk({tag, "_stall"}, {31'd0, stall_mem}, 32'd0);
        chk({tag, "_is_load_mem"}, {31'd0, is_load_mem}, 32'd1);
        tick();
        chk({tag, "_wb_bubble"}, {31'd0, wb_bubble}, 32'd0);
        chk({tag, "_wb_res1"}, wb_result_out_1, exp_val);
        chk({tag, "_wb_res2"}, wb_result_out_2, a + 32'd4);
        chk({tag, "_rd_en_after"}, {31'd0, rd_en}, 32'd0);
    endtask

    // Misaligned load: two reads, one stall cycle, result extracted in wb.
    task automatic split_load(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] exp_val);
        drive(op, 5'd2, 32'h0, 32'h0, a, 1'b1, 1'b0);
        tick();
        idle_ex();
        chk({tag, "_rd_addr0"}, rd_addr, a0);
        chk({tag, "_stall0"}, {31'd0, stall_mem}, 32'd1);
        tick();
        chk({tag, "_rd_addr1"}, rd_addr, a1);
        chk({tag, "_rd_en1"}, {31'd0, rd_en}, 32'd1);
        chk({tag, "_stall1"}, {31'd0, stall_mem}, 32'd0);
        chk({tag, "_wb_bubble1"}, {31'd0, wb_bubble}, 32'd1);
        tick();
        chk({tag, "_wb_bubble2"}, {31'd0, wb_bubble}, 32'd0);
        chk({tag, "_result"}, wb_result_out_1, exp_val);
        chk({tag, "_stall2"}, {31'd0, stall_mem}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0;
        ex_opcode = 5'd0; ex_tgt_2 = 5'd0; ex_result_1 = 32'd0; ex_result_2 = 32'd0;
        ex_addr = 32'd0; ex_is_store = 1'b0;
        idle_ex();
        tick();
        tick();
        chk("rst_mem_bubble", {31'd0, mem_bubble}, 32'd1);
        chk("rst_wb_bubble", {31'd0, wb_bubble}, 32'd1);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_tgts", {12'd0, mem_tgt_1, mem_tgt_2, wb_tgt_1, wb_tgt_2}, 32'd0);
        chk("rst_flags", {30'd0, is_load_mem, halt_in_wb}, 32'd0);
        rst = 1'b0;

        aligned_load("lw100", 5'd3, 32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF);
        aligned_load("lb203", 5'd9, 32'h0000_0203, 32'h0000_0200, 32'h0000_00AA);
        aligned_load("lh202", 5'd6, 32'h0000_0202, 32'h0000_0200, 32'h0000_AABB);
        aligned_load("lb201", 5'd10, 32'h0000_0201, 32'h0000_0200, 32'h0000_00CC);

        split_load("lw301", 5'd3, 32'h0000_0301, 32'h0000_0300, 32'h0000_0304, 32'h5544_3322);
        split_load("lhwrap", 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_F012);

        // Non-load passes its results straight through.
        drive(5'd1, 5'd5, 32'd7, 32'd9, 32'h0, 1'b0, 1'b0);
        tick();
        idle_ex();
        chk("alu_mem_tgt", {27'd0, mem_tgt_1}, 32'd5);
        chk("alu_mem_res", mem_result_out_1, 32'd7);
        chk("alu_rd_en", {31'd0, rd_en}, 32'd0);
        chk("alu_opcode", {27'd0, mem_opcode_out}, 32'd1);
        tick();
        chk("alu_wb_tgt", {27'd0, wb_tgt_1}, 32'd5);
        chk("alu_wb_res1", wb_result_out_1, 32'd7);
        chk("alu_wb_res2", wb_result_out_2, 32'd9);

        // Halt in the middle of a split holds address, stall and the buffered word.
        drive(5'd3, 5'd3, 32'h0, 32'h0, 32'h0000_0302, 1'b1, 1'b0);
        tick();
        idle_ex();
        chk("hsplit_stall0", {31'd0, stall_mem}, 32'd1);
        tick();
        halt = 1'b1;
        chk("hsplit_addr_a", rd_addr, 32'h0000_0304);
        tick();
        chk("hsplit_addr_b", rd_addr, 32'h0000_0304);
        chk("hsplit_stall_b", {31'd0, stall_mem}, 32'd0);
        chk("hsplit_wb_bub", {31'd0, wb_bubble}, 32'd1);
        tick();
        chk("hsplit_addr_c", rd_addr, 32'h0000_0304);
        halt = 1'b0;
        tick();
        chk("hsplit_result", wb_result_out_1, 32'h6655_4433);
        chk("hsplit_wb_tgt", {27'd0, wb_tgt_1}, 32'd3);

        // Reset while a split is in progress drops the load.
        drive(5'd3, 5'd4, 32'h0, 32'h0, 32'h0000_0303, 1'b1, 1'b0);
        tick();
        idle_ex();
        tick();
        chk("rsplit_in_split", rd_addr, 32'h0000_0304);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsplit_mem_bub", {31'd0, mem_bubble}, 32'd1);
        chk("rsplit_wb_bub", {31'd0, wb_bubble}, 32'd1);
        chk("rsplit_stall", {31'd0, stall_mem}, 32'd0);
        chk("rsplit_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rsplit_tgts", {12'd0, mem_tgt_1, mem_tgt_2, wb_tgt_1, wb_tgt_2}, 32'd0);
        tick();
        chk("rsplit_idle", {31'd0, stall_mem}, 32'd0);
        // An aligned load right after reset must behave as in IDLE.
        aligned_load("post_rst", 5'd3, 32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF);

        // A halt reaching wb blocks everything behind it.
        drive(5'd1, 5'd6, 32'd1, 32'd0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(5'd3, 5'd7, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 1'b0);
        chk("halt_not_yet", {31'd0, halt_in_wb}, 32'd0);
        tick();
        chk("halt_in_wb", {31'd0, halt_in_wb}, 32'd1);
        chk("halt_wb_valid", {31'd0, wb_bubble}, 32'd0);
        chk("halt_mem_bub", {31'd0, mem_bubble}, 32'd1);
        chk("halt_rd_en", {31'd0, rd_en}, 32'd0);
        tick();
        chk("halt_sticky", {31'd0, halt_in_wb}, 32'd1);
        chk("halt_wb_bub", {31'd0, wb_bubble}, 32'd1);
        chk("halt_rd_en2", {31'd0, rd_en}, 32'd0);
        idle_ex();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_cleared", {31'd0, halt_in_wb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
